// File: rtl/keypad_accumulator.sv
// Debounced keypad front end that accumulates digit keys into a shift register,
// with backspace, clear and enter actions applied once per press/release cycle.
module keypad_accumulator #(
  parameter int DIGIT_W      = 4,
  parameter int NUM_DIGITS   = 8,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [4:0]                      teclas,
  input  logic                            val,
  output logic [DIGIT_W*NUM_DIGITS-1:0]   value,
  output logic [4:0]                      digit_count,
  output logic                            full,
  output logic [DIGIT_W*NUM_DIGITS-1:0]   entered_value,
  output logic                            entered,
  output logic                            overflow
);

  localparam int VW = DIGIT_W * NUM_DIGITS;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_DEB_PRESS = 2'd1;
  localparam logic [1:0] ST_HELD      = 2'd2;
  localparam logic [1:0] ST_DEB_REL   = 2'd3;

  localparam logic [7:0] DEB_TARGET = 8'(DEBOUNCE_CYC);
  localparam logic [4:0] DIGIT_LIM  = 5'(1 << DIGIT_W);
  localparam logic [4:0] MAX_COUNT  = 5'(NUM_DIGITS);

  localparam logic [4:0] KEY_CLEAR = 5'h10;
  localparam logic [4:0] KEY_BKSP  = 5'h11;
  localparam logic [4:0] KEY_ENTER = 5'h12;

  logic [1:0]    r_state;
  logic [7:0]    r_debCnt;
  logic [4:0]    r_key;
  logic [VW-1:0] r_value;
  logic [4:0]    r_count;
  logic [VW-1:0] r_enteredValue;
  logic          r_entered;
  logic          r_overflow;

  logic [1:0]    w_stateNext;
  logic [7:0]    w_cntNext;
  logic [7:0]    w_cntInc;
  logic          w_latch;
  logic          w_act;
  logic          w_isDigit;
  logic [VW-1:0] w_digitExt;

  assign w_cntInc  = r_debCnt + 8'd1;
  assign w_isDigit = (r_key[4] == 1'b0) && ({1'b0, r_key[3:0]} < DIGIT_LIM);

  always_comb begin
    w_digitExt                = '0;
    w_digitExt[DIGIT_W-1:0]   = r_key[DIGIT_W-1:0];
  end

  // val is sampled directly; the counter only advances while val holds its new level.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_debCnt;
    w_latch     = 1'b0;
    w_act       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cntNext = 8'd0;
        if (val) begin
          w_cntNext = 8'd1;
          if (DEBOUNCE_CYC == 1) begin
            w_stateNext = ST_HELD;
            w_latch     = 1'b1;
          end else begin
            w_stateNext = ST_DEB_PRESS;
          end
        end
      end
      ST_DEB_PRESS: begin
        if (val) begin
          if (w_cntInc >= DEB_TARGET) begin
            w_stateNext = ST_HELD;
            w_cntNext   = DEB_TARGET;
            w_latch     = 1'b1;
          end else begin
            w_cntNext = w_cntInc;
          end
        end else begin
          w_stateNext = ST_IDLE;
          w_cntNext   = 8'd0;
        end
      end
      ST_HELD: begin
        if (!val) begin
          if (DEBOUNCE_CYC == 1) begin
            w_stateNext = ST_IDLE;
            w_cntNext   = 8'd0;
            w_act       = 1'b1;
          end else begin
            w_stateNext = ST_DEB_REL;
            w_cntNext   = 8'd1;
          end
        end
      end
      ST_DEB_REL: begin
        if (!val) begin
          if (w_cntInc >= DEB_TARGET) begin
            w_stateNext = ST_IDLE;
            w_cntNext   = 8'd0;
            w_act       = 1'b1;
          end else begin
            w_cntNext = w_cntInc;
          end
        end else begin
          w_stateNext = ST_HELD;
          w_cntNext   = 8'd0;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
        w_cntNext   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_debCnt       <= 8'd0;
      r_key          <= 5'd0;
      r_value        <= '0;
      r_count        <= 5'd0;
      r_enteredValue <= '0;
      r_entered      <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_debCnt   <= w_cntNext;
      r_entered  <= 1'b0;
      r_overflow <= 1'b0;
      if (w_latch) begin
        r_key <= teclas;
      end
      // Action decoded from the key latched at press time, not the live code.
      if (w_act) begin
        if (w_isDigit) begin
          if (r_count < MAX_COUNT) begin
            r_value <= (r_value << DIGIT_W) | w_digitExt;
            r_count <= r_count + 5'd1;
          end else begin
            r_overflow <= 1'b1;
          end
        end else if (r_key == KEY_BKSP) begin
          if (r_count != 5'd0) begin
            r_value <= r_value >> DIGIT_W;
            r_count <= r_count - 5'd1;
          end
        end else if (r_key == KEY_CLEAR) begin
          r_value <= '0;
          r_count <= 5'd0;
        end else if (r_key == KEY_ENTER) begin
          r_enteredValue <= r_value;
          r_entered      <= 1'b1;
          r_value        <= '0;
          r_count        <= 5'd0;
        end
      end
    end
  end

  assign value         = r_value;
  assign digit_count   = r_count;
  assign full          = (r_count == MAX_COUNT);
  assign entered_value = r_enteredValue;
  assign entered       = r_entered;
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_keypad_accumulator.sv
// Directed and randomized checks of keypad_accumulator against a digit-list model
// (DIGIT_W=4, NUM_DIGITS=8, DEBOUNCE_CYC=2).
module tb_keypad_accumulator;

  logic        clk;
  logic        reset_n;
  logic [4:0]  teclas;
  logic        val;
  logic [31:0] value;
  logic [4:0]  digit_count;
  logic        full;
  logic [31:0] entered_value;
  logic        entered;
  logic        overflow;

  int nChecks = 0;
  int nFails  = 0;

  int          q[$];
  logic [31:0] mEntered = 32'd0;

  keypad_accumulator #(
    .DIGIT_W     (4),
    .NUM_DIGITS  (8),
    .DEBOUNCE_CYC(2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .teclas       (teclas),
    .val          (val),
    .value        (value),
    .digit_count  (digit_count),
    .full         (full),
    .entered_value(entered_value),
    .entered      (entered),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Value is the held digit list read as a base-16 number, oldest digit most significant.
  function automatic logic [31:0] modelValue();
    logic [31:0] v = 32'd0;
    foreach (q[i]) v = v * 32'd16 + 32'(q[i]);
    return v;
  endfunction

  function automatic void applyModel(input logic [4:0] code, output bit expEnt, output bit expOvf);
    expEnt = 1'b0;
    expOvf = 1'b0;
    if (code < 5'd16) begin
      if (q.size() < 8) q.push_back(int'(code));
      else expOvf = 1'b1;
    end else if (code == 5'h11) begin
      if (q.size() > 0) void'(q.pop_back());
    end else if (code == 5'h10) begin
      q.delete();
    end else if (code == 5'h12) begin
      mEntered = modelValue();
      expEnt   = 1'b1;
      q.delete();
    end
  endfunction

  task automatic checkState(input string tag);
    checkOutput({tag, " value"}, value, modelValue());
    checkOutput({tag, " count"}, 32'(digit_count), 32'(q.size()));
    checkOutput({tag, " full"}, 32'(full), 32'(q.size() == 8));
    checkOutput({tag, " entered_value"}, entered_value, mEntered);
  endtask

  // One press/release: the action must land exactly two edges after val falls.
  task automatic applyStimulus(input logic [4:0] code, input int hold, input bit glitchLow, input bit scramble);
    int prevCount;
    bit expEnt, expOvf;
    @(negedge clk);
    teclas = code;
    val    = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (scramble && i >= 1) teclas = 5'($urandom);
      if (glitchLow) val = (i != 2);
    end
    val       = 1'b0;
    prevCount = q.size();
    applyModel(code, expEnt, expOvf);
    @(posedge clk); #1;
    checkOutput("latency count", 32'(digit_count), 32'(prevCount));
    @(posedge clk); #1;
    checkState("action");
    checkOutput("entered pulse", 32'(entered), 32'(expEnt));
    checkOutput("overflow pulse", 32'(overflow), 32'(expOvf));
    @(posedge clk); #1;
    checkOutput("entered low", 32'(entered), 32'd0);
    checkOutput("overflow low", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [4:0] code;
    int         sel;

    reset_n = 1'b0;
    val     = 1'b0;
    teclas  = 5'd0;
    repeat (3) @(negedge clk);
    checkState("reset");
    checkOutput("reset entered", 32'(entered), 32'd0);
    checkOutput("reset overflow", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] digits 1,2,3");
    applyStimulus(5'h01, 5, 1'b0, 1'b0);
    applyStimulus(5'h02, 5, 1'b0, 1'b0);
    applyStimulus(5'h03, 5, 1'b0, 1'b0);
    checkOutput("req032 value", value, 32'h00000123);

    $display("[TB] glitches");
    @(negedge clk);
    teclas = 5'h07;
    val    = 1'b1;
    @(negedge clk);
    val = 1'b0;
    repeat (6) @(negedge clk);
    checkState("high glitch");
    applyStimulus(5'h04, 6, 1'b1, 1'b0);
    checkOutput("low glitch value", value, 32'h00001234);

    $display("[TB] overflow");
    applyStimulus(5'h12, 3, 1'b0, 1'b0);
    for (int d = 1; d <= 9; d++) applyStimulus(5'(d), 4, 1'b0, 1'b1);
    checkOutput("req034 value", value, 32'h12345678);
    checkOutput("req034 full", 32'(full), 32'd1);

    $display("[TB] backspace and enter");
    applyStimulus(5'h10, 3, 1'b0, 1'b0);
    applyStimulus(5'h0A, 3, 1'b0, 1'b0);
    applyStimulus(5'h0B, 3, 1'b0, 1'b0);
    applyStimulus(5'h11, 3, 1'b0, 1'b0);
    applyStimulus(5'h12, 3, 1'b0, 1'b0);
    checkOutput("req035 entered_value", entered_value, 32'h0000000A);
    applyStimulus(5'h11, 3, 1'b0, 1'b0);

    $display("[TB] ignore and clear");
    applyStimulus(5'h03, 3, 1'b0, 1'b0);
    applyStimulus(5'h05, 3, 1'b0, 1'b0);
    applyStimulus(5'h09, 3, 1'b0, 1'b0);
    applyStimulus(5'h1F, 3, 1'b0, 1'b0);
    checkOutput("req037 ignore value", value, 32'h00000359);
    applyStimulus(5'h10, 3, 1'b0, 1'b0);
    checkOutput("req037 entered kept", entered_value, 32'h0000000A);

    $display("[TB] reset during held key");
    applyStimulus(5'h06, 3, 1'b0, 1'b0);
    @(negedge clk);
    teclas = 5'h05;
    val    = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    val     = 1'b0;
    q.delete();
    mEntered = 32'd0;
    repeat (5) @(negedge clk);
    checkState("req036");
    checkOutput("req036 entered", 32'(entered), 32'd0);

    $display("[TB] enter on empty and random presses");
    applyStimulus(5'h12, 2, 1'b0, 1'b0);
    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 4 || sel == 9) code = 5'($urandom_range(0, 15));
      else if (sel == 5) code = 5'h11;
      else if (sel == 6) code = 5'h10;
      else if (sel == 7) code = 5'h12;
      else code = 5'($urandom_range(19, 31));
      applyStimulus(code, int'($urandom_range(2, 6)), 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/keypad_accumulator.md
KEYPAD_ACCUMULATOR -- requirements
Module: keypad_accumulator

Interface
REQ-001 Parameter DIGIT_W, default 4, bits per digit (legal range 1..4).
REQ-002 Parameter NUM_DIGITS, default 8, maximum digits held (legal range 1..16).
REQ-003 Parameter DEBOUNCE_CYC, default 4, consecutive stable samples needed to accept a press or a release (legal range 1..255).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  reset, synchronous and active-low, sampled on the rising edge of clk.
REQ-006 teclas  input  5  key code from the keypad encoder; valid while val is high.
REQ-007 val  input  1  key-down strobe, asynchronous to clk, may bounce.
REQ-008 value  output  DIGIT_W*NUM_DIGITS  accumulated digits; newest digit in the least-significant DIGIT_W bits.
REQ-009 digit_count  output  5  number of digits currently held (0..NUM_DIGITS).
REQ-010 full  output  1  high when digit_count equals NUM_DIGITS.
REQ-011 entered_value  output  DIGIT_W*NUM_DIGITS  value captured by the last ENTER.
REQ-012 entered  output  1  one-cycle pulse on ENTER.
REQ-013 overflow  output  1  one-cycle pulse when a digit is dropped because the block is full.

Function
REQ-014 Key decode: teclas[4]=0 and teclas[3:0] < 2**DIGIT_W means DIGIT; 5'h10 means CLEAR; 5'h11 means BACKSPACE; 5'h12 means ENTER; any other code means IGNORE.
REQ-015 The FSM has four states: IDLE, DEB_PRESS, HELD and DEB_REL, with one shared debounce counter.
REQ-016 IDLE: val=1 goes to DEB_PRESS with counter=1; when DEBOUNCE_CYC=1 it goes directly to HELD.
REQ-017 DEB_PRESS: val=1 increments the counter; when the counter reaches DEBOUNCE_CYC, the state goes to HELD and teclas is latched into the internal key register on that same edge; val=0 returns to IDLE with no action.
REQ-018 HELD: val=0 goes to DEB_REL with counter=1, or performs the action immediately when DEBOUNCE_CYC=1; val=1 stays in HELD; teclas changes while in HELD are ignored.
REQ-019 DEB_REL: val=0 increments the counter; when the counter reaches DEBOUNCE_CYC, the state goes to IDLE and the latched key's action is applied on that same edge; val=1 returns to HELD and keeps the latched key.
REQ-020 DIGIT action with digit_count < NUM_DIGITS: value <= {value shifted left DIGIT_W, digit}, digit_count +1.
REQ-021 DIGIT action when full: value and digit_count are unchanged, and overflow pulses for one cycle.
REQ-022 BACKSPACE action: value shifted right DIGIT_W with zero fill, digit_count -1; when digit_count=0 it is a no-op.
REQ-023 CLEAR action: value=0, digit_count=0; entered_value is unchanged.
REQ-024 ENTER action: entered_value <= value and entered pulses for one cycle; on the same edge value=0 and digit_count=0; ENTER with digit_count=0 still pulses and stores 0.
REQ-025 IGNORE action: no state change other than the FSM returning to IDLE.
REQ-026 At most one action executes per press/release cycle; a held key never auto-repeats.
REQ-027 full is combinational from digit_count; entered and overflow are registered and are high for exactly one cycle.
REQ-028 An undefined FSM encoding returns the FSM to IDLE on the next edge, and the debounce counter clears.
REQ-029 The debounce counter is never more than 8 bits wide and saturates at DEBOUNCE_CYC.

Reset
REQ-030 reset_n=0 at a rising edge sets the FSM to IDLE and clears the counter, key register, value, digit_count, entered_value, entered and overflow to 0.
REQ-031 Reset has priority over every action; reset mid-press discards the latched key, and val still high after reset must pass the full press debounce again.

Verification (DIGIT_W=4, NUM_DIGITS=8, DEBOUNCE_CYC=2)
REQ-032 Keys 1,2,3 each held 5 cycles then released 5 cycles -> value=32'h00000123, digit_count=3, each update 2 edges after val falls.
REQ-033 val glitches high for 1 cycle with teclas=5'h07 -> no change to value; 1-cycle low glitch during a held 5'h04 -> exactly one digit 4 added.
REQ-034 Nine digits 1..9 entered -> value=32'h12345678, full=1, overflow pulses once on the 9th release.
REQ-035 Digits A,B then BACKSPACE then ENTER -> entered_value=32'h0000000A, entered high for 1 cycle, value=0, digit_count=0.
REQ-036 Press 5'h05, assert reset_n=0 for 1 cycle while in HELD, then release -> no digit added, all outputs 0.
REQ-037 Code 5'h1F, then CLEAR with digit_count=3 -> 5'h1F has no effect; CLEAR gives value=0 and digit_count=0, and entered_value is unchanged.
